// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  localparam logic [7:0] LOSS_SAT = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset/lock from the reference clock and gates user reset on stable lock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 7,
  parameter int unsigned CNT_W            = 20
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LAST  = 4'(MAX_RETRY);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_s;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clkin1),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_LAST) begin
            state_d = FAIL;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        // A drop here is treated as lock settling, not a failed attempt.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          if (loss_q != LOSS_SAT) loss_d = loss_q + 8'd1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Restart overrides the transition but keeps any loss counted above.
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end

    if (state_d == RUN) retry_d = '0;
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked_ok <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst   <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst_n <= (state_d == RUN);
      locked_ok <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  logic       clkin1 = 1'b0;
  logic       rst, pll_lock, restart;
  logic       pll_rst, sys_rst_n, locked_ok, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(20),
    .LOCK_STABLE_CYC (8),
    .MAX_RETRY       (2),
    .CNT_W           (8)
  ) dut (
    .clkin1       (clkin1),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .locked_ok    (locked_ok),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clkin1 = ~clkin1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clkin1);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_locked_ok"}, locked_ok, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_loss"}, lock_loss_cnt, 0);
  endtask

  task automatic wait_run(input string tag, input int max);
    int n;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, sys_rst_n, 1);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    tick(2);
    chk_reset_vals("por");
    rst = 1'b0;

    // Nominal lock
    tick(3);
    chk("nom_rst_pulse_hi", pll_rst, 1);
    tick();
    chk("nom_rst_pulse_lo", pll_rst, 0);
    tick(6);
    pll_lock = 1'b1;
    tick(10);
    chk("nom_pre_release", sys_rst_n, 0);
    tick();
    chk("nom_release", sys_rst_n, 1);
    chk("nom_locked_ok", locked_ok, 1);
    chk("nom_retry", retry_cnt, 0);
    chk("nom_pll_rst", pll_rst, 0);

    // Lock loss in RUN, 3-cycle drop
    pll_lock = 1'b0;
    tick(2);
    chk("loss_still_run", sys_rst_n, 1);
    tick();
    chk("loss_sys_rst_n", sys_rst_n, 0);
    chk("loss_cnt1", lock_loss_cnt, 1);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_locked_ok", locked_ok, 0);
    pll_lock = 1'b1;
    tick(3);
    chk("loss_pulse_end_hi", pll_rst, 1);
    tick();
    chk("loss_pulse_lo", pll_rst, 0);
    tick(8);
    chk("loss_pre_relock", sys_rst_n, 0);
    tick();
    chk("loss_relock", sys_rst_n, 1);

    // One timeout, then a glitch in STABLE with retry_cnt=1
    pll_lock = 1'b0;
    tick(26);
    chk("to1_wait_pll_rst", pll_rst, 0);
    chk("to1_wait_retry", retry_cnt, 0);
    tick();
    chk("to1_retry_pll_rst", pll_rst, 1);
    chk("to1_retry", retry_cnt, 1);
    tick(4);
    chk("to1_second_wait", pll_rst, 0);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick(2);
    chk("glitch_retry_kept", retry_cnt, 1);
    chk("glitch_no_release", sys_rst_n, 0);
    tick(8);
    chk("glitch_pre_release", sys_rst_n, 0);
    tick();
    chk("glitch_release", sys_rst_n, 1);
    chk("glitch_retry_clr", retry_cnt, 0);

    // Late lock in the last window
    pll_lock = 1'b0;
    tick(50);
    chk("late_retry1", retry_cnt, 1);
    tick();
    chk("late_retry2", retry_cnt, 2);
    tick(21);
    pll_lock = 1'b1;
    tick(3);
    chk("late_no_fail", fail, 0);
    chk("late_pll_rst", pll_rst, 0);
    chk("late_retry_held", retry_cnt, 2);
    tick(7);
    chk("late_pre_release", sys_rst_n, 0);
    tick();
    chk("late_release", sys_rst_n, 1);
    chk("late_retry_clr", retry_cnt, 0);

    // Full timeout to FAIL, then restart
    pll_lock = 1'b0;
    tick(50);
    chk("to_wait2_pll_rst", pll_rst, 0);
    tick();
    chk("to_pulse3_start", pll_rst, 1);
    chk("to_retry2", retry_cnt, 2);
    tick(3);
    chk("to_pulse3_end", pll_rst, 1);
    tick();
    chk("to_wait3", pll_rst, 0);
    tick(19);
    chk("to_pre_fail", fail, 0);
    tick();
    chk("to_fail", fail, 1);
    chk("to_fail_pll_rst", pll_rst, 1);
    chk("to_fail_sys_rst_n", sys_rst_n, 0);
    chk("to_fail_retry", retry_cnt, 2);
    tick(10);
    chk("to_fail_sticky", fail, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_fail_clr", fail, 0);
    chk("rs_retry_clr", retry_cnt, 0);
    chk("rs_pll_rst", pll_rst, 1);
    chk("rs_loss_kept", lock_loss_cnt, 4);
    tick(3);
    chk("rs_pulse_hi", pll_rst, 1);
    tick();
    chk("rs_pulse_lo", pll_rst, 0);

    // Reset while in STABLE at cnt=5
    pll_lock = 1'b1;
    tick(8);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    wait_run("mid_rst_relock", 60);

    // Loss and restart on the same edge
    pll_lock = 1'b0;
    tick(2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("both_loss", lock_loss_cnt, 1);
    chk("both_sys_rst_n", sys_rst_n, 0);
    chk("both_pll_rst", pll_rst, 1);

    // rst beats restart
    rst = 1'b1; restart = 1'b1;
    tick();
    rst = 1'b0; restart = 1'b0;
    chk("rst_wins_loss", lock_loss_cnt, 0);
    chk("rst_wins_pll_rst", pll_rst, 1);

    // Saturation of lock_loss_cnt
    pll_lock = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_run("sat_relock", 60);
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      if (i == 254) chk("sat_255", lock_loss_cnt, 255);
    end
    chk("sat_hold", lock_loss_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
